aes_round_ctrl: RTL and testbench

Sequencer for the iterative AES-128 encryption core. It accepts one block per input handshake and pulses the datapath load for the initial AddRoundKey. It then steps the shared round datapath through rounds 1..NR, selecting the last-round path (no MixColumns) on round NR, and presents a completion handshake. It owns no 128-bit data; it drives select and enable strobes to the state register and the round-key index to the key schedule.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_round_ctrl.sv | 127 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 iterative core control path.
//   state_e   : sequencer states (IDLE, RUN, DONE), 2-bit encoding
//   RND_W     : width of the round-key index
//   NR_AES128 : round count for AES-128
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int RND_W     = 4;
    localparam int NR_AES128 = 10;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 encryption core.
// Accepts one block per input handshake, pulses the datapath load for the
// initial AddRoundKey, steps the shared round datapath through rounds 1..NR
// (last-round path on round NR) and holds a completion handshake until the
// consumer takes the ciphertext. Owns no data; drives strobes and key index.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   SOFT_CLR   in   synchronous abort back to IDLE (priority over handshakes)
//   IN_VALID   in   plaintext block and key presented
//   IN_READY   out  controller can accept a block
//   OUT_VALID  out  state register holds the ciphertext
//   OUT_READY  in   consumer accepts the ciphertext
//   DP_LOAD    out  state register captures IN_DATA ^ round key 0
//   DP_EN      out  state register captures the round datapath output
//   DP_LAST    out  selects the last-round path (no MixColumns)
//   RND_IDX    out  round-key index to the key schedule
//   BUSY       out  controller is in RUN or DONE
//   BLK_CNT    out  completed-block count, wraps modulo 2^CNT_W
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR        = NR_AES128,
    parameter int ROUND_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SOFT_CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             DP_LOAD,
    output logic             DP_EN,
    output logic             DP_LAST,
    output logic [RND_W-1:0] RND_IDX,
    output logic             BUSY,
    output logic [CNT_W-1:0] BLK_CNT
);

    // Latency counter only needs to reach ROUND_LAT-1; keep at least 1 bit.
    localparam int LAT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;

    state_e             state_q, state_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic round_end;
    logic last_round;

    assign round_end  = (lat_q == LAT_W'(ROUND_LAT - 1));
    assign last_round = (rnd_q == RND_W'(NR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        if (SOFT_CLR) begin
            state_d = IDLE;
            rnd_d   = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        state_d = RUN;
                        rnd_d   = RND_W'(1);
                        lat_d   = '0;
                    end
                end
                RUN: begin
                    if (round_end) begin
                        if (last_round) begin
                            // RND_IDX keeps NR through DONE.
                            state_d = DONE;
                        end else begin
                            rnd_d = rnd_q + RND_W'(1);
                            lat_d = '0;
                        end
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                DONE: begin
                    // Return to IDLE rather than accepting directly, so a new
                    // block is taken no earlier than the following cycle.
                    if (OUT_READY) begin
                        state_d = IDLE;
                        rnd_d   = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // IN_READY is gated with rst_n so it is low for the whole reset window,
    // not just after the first edge.
    assign IN_READY  = (state_q == IDLE) && rst_n;
    assign DP_LOAD   = IN_READY && IN_VALID && !SOFT_CLR;
    assign DP_EN     = (state_q == RUN) && round_end;
    assign DP_LAST   = (state_q == RUN) && last_round;
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q == RUN) || (state_q == DONE);
    assign RND_IDX   = rnd_q;
    assign BLK_CNT   = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

    localparam int NDUT = 3;
    localparam int NR_T  [NDUT] = '{10, 10, 3};
    localparam int LAT_T [NDUT] = '{1, 3, 2};
    localparam int CW_T  [NDUT] = '{16, 16, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_clr = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    // Packed observation per instance:
    // {IN_READY, OUT_VALID, DP_LOAD, DP_EN, DP_LAST, BUSY, RND_IDX[3:0], BLK_CNT (zero-extended to 16)}
    logic [25:0] obs [NDUT];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int CW = CW_T[gi];
        logic          ir, ov, ld, en, ls, bs;
        logic [3:0]    rnd;
        logic [CW-1:0] cnt;

        aes_round_ctrl #(
            .NR        (NR_T[gi]),
            .ROUND_LAT (LAT_T[gi]),
            .CNT_W     (CW)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .SOFT_CLR  (soft_clr),
            .IN_VALID  (in_valid),
            .IN_READY  (ir),
            .OUT_VALID (ov),
            .OUT_READY (out_ready),
            .DP_LOAD   (ld),
            .DP_EN     (en),
            .DP_LAST   (ls),
            .RND_IDX   (rnd),
            .BUSY      (bs),
            .BLK_CNT   (cnt)
        );

        assign obs[gi] = {ir, ov, ld, en, ls, bs, rnd, 16'(cnt)};
    end

    // Reference model: a block is described by how many cycles have elapsed
    // since it was accepted (k). Rounds occupy k = 1..NR*LAT, round r spans
    // k in ((r-1)*LAT, r*LAT], and the result waits for pickup after that.
    bit m_active [NDUT];
    int m_k      [NDUT];
    int m_cnt    [NDUT];

    function automatic logic [25:0] exp_vec(int i);
        logic       ir, ov, ld, en, ls, bs;
        logic [3:0] rnd;
        logic [15:0] cnt;
        ir = 0; ov = 0; ld = 0; en = 0; ls = 0; bs = 0; rnd = 0; cnt = 0;
        if (rst_n) begin
            cnt = 16'(m_cnt[i]);
            if (!m_active[i]) begin
                ir = 1;
                ld = in_valid && !soft_clr;
            end else if (m_k[i] <= NR_T[i] * LAT_T[i]) begin
                bs  = 1;
                rnd = 4'((m_k[i] + LAT_T[i] - 1) / LAT_T[i]);
                en  = (m_k[i] % LAT_T[i] == 0);
                ls  = (int'(rnd) == NR_T[i]);
            end else begin
                bs  = 1;
                ov  = 1;
                rnd = 4'(NR_T[i]);
            end
        end
        return {ir, ov, ld, en, ls, bs, rnd, cnt};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_active[i] = 0;
            m_k[i]      = 0;
            m_cnt[i]    = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                m_active[i] = 0; m_k[i] = 0; m_cnt[i] = 0;
            end else if (soft_clr) begin
                m_active[i] = 0;
            end else if (!m_active[i]) begin
                if (in_valid) begin m_active[i] = 1; m_k[i] = 1; end
            end else if (m_k[i] <= NR_T[i] * LAT_T[i]) begin
                m_k[i]++;
            end else if (out_ready) begin
                m_active[i] = 0;
                m_cnt[i] = (m_cnt[i] + 1) % (1 << CW_T[i]);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst_n = (c >= 2);
            soft_clr = 0; in_valid = 0; out_ready = 0;
            #1;
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
                end
            end
            @(posedge clk);
            model_step();
        end
    endtask

    task automatic test_single_block();
        int first_ov [NDUT];
        int en_cnt   [NDUT];
        int last_en  [NDUT];
        int exp_lat;
        for (int i = 0; i < NDUT; i++) begin first_ov[i] = -1; en_cnt[i] = 0; last_en[i] = 0; end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in_valid = (c == 0); out_ready = 1; soft_clr = 0;
            #1;
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL single dut%0d cyc%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
                end
                if (obs[i][24] && first_ov[i] < 0) first_ov[i] = c;
                if (obs[i][22]) en_cnt[i]++;
                if (obs[i][22] && obs[i][21]) last_en[i]++;
            end
            @(posedge clk);
            model_step();
        end
        for (int i = 0; i < NDUT; i++) begin
            exp_lat = NR_T[i] * LAT_T[i] + 1;
            n_cmp++;
            if (first_ov[i] != exp_lat) begin
                n_fail++;
                $display("FAIL latency dut%0d got=%0d exp=%0d", i, first_ov[i], exp_lat);
            end
            n_cmp++;
            if (en_cnt[i] != NR_T[i] || last_en[i] != 1) begin
                n_fail++;
                $display("FAIL en_pulses dut%0d got=%0d/%0d exp=%0d/1", i, en_cnt[i], last_en[i], NR_T[i]);
            end
        end
        n_cmp++;
        if (obs[0][15:0] !== 16'd1) begin
            n_fail++;
            $display("FAIL single_cnt got=%0d exp=1", obs[0][15:0]);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            in_valid  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = (c >= 38);
            soft_clr  = 0;
            #1;
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL backpressure dut%0d cyc%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
                end
            end
            @(posedge clk);
            model_step();
            if (c == 38) in_valid = 0;
        end
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        #1;
        n_cmp++;
        if (obs[0][15:0] !== 16'd2) begin
            n_fail++;
            $display("FAIL backpressure_cnt got=%0d exp=2", obs[0][15:0]);
        end
        @(posedge clk);
        model_step();
    endtask

    task automatic test_soft_clr();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            soft_clr  = (c == 0) || (c == 6);
            in_valid  = (c == 0) || (c == 1) || (c == 8);
            out_ready = 1;
            #1;
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL soft_clr dut%0d cyc%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (obs[0][19:16] !== 4'd5) begin
                    n_fail++;
                    $display("FAIL soft_clr_at_rnd got=%0d exp=5", obs[0][19:16]);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (obs[0][25:20] !== 6'b100000 || obs[0][19:16] !== 4'd0 || obs[0][15:0] !== 16'd2) begin
                    n_fail++;
                    $display("FAIL soft_clr_after got=%h exp=ir1 rnd0 cnt2", obs[0]);
                end
            end
            @(posedge clk);
            model_step();
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            soft_clr = 0; out_ready = 1;
            in_valid = (c == 0);
            if (c == 6) rst_n = 1;
            #1;
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL async_rst dut%0d cyc%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
                end
            end
            if (c == 4) begin
                #1 rst_n = 0;
                model_reset();
                #1;
                for (int i = 0; i < NDUT; i++) begin
                    n_cmp++;
                    if (obs[i] !== 26'd0) begin
                        n_fail++;
                        $display("FAIL async_rst_now dut%0d got=%h exp=0", i, obs[i]);
                    end
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (obs[0][25] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL async_release_ready got=%b exp=1", obs[0][25]);
                end
            end
            @(posedge clk);
            model_step();
        end
    endtask

    task automatic test_back_to_back();
        int prev_ld = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            soft_clr = 0; in_valid = 1; out_ready = 1;
            #1;
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL b2b dut%0d cyc%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
                end
            end
            if (obs[0][23]) begin
                if (prev_ld >= 0) begin
                    n_cmp++;
                    if (c - prev_ld != 12) begin
                        n_fail++;
                        $display("FAIL b2b_spacing got=%0d exp=12", c - prev_ld);
                    end
                end
                prev_ld = c;
            end
            if (c == 36) begin
                n_cmp++;
                if (obs[0][15:0] !== 16'd3) begin
                    n_fail++;
                    $display("FAIL b2b_cnt3 got=%0d exp=3", obs[0][15:0]);
                end
            end
            if (c == 40) begin
                n_cmp++;
                if (obs[2][15:0] !== 16'd1) begin
                    n_fail++;
                    $display("FAIL b2b_wrap got=%0d exp=1", obs[2][15:0]);
                end
            end
            @(posedge clk);
            model_step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            soft_clr  = ($urandom_range(0, 19) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
                end
            end
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_soft_clr();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
